// File: rtl/ahb_ram_responder_pkg.sv
// rtl/ahb_ram_responder_pkg.sv - AHB-Lite encodings, responder FSM states and lane helpers
package ahb_ram_responder_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    // Each state describes the data phase currently on the bus.
    typedef enum logic [1:0] {
        AHBR_IDLE,
        AHBR_WAIT,
        AHBR_ERR1,
        AHBR_ERR2
    } ahbr_state_e;

    // Byte lanes touched by a transfer of the given size at the given low address bits.
    function automatic logic [3:0] byte_lanes(input logic [2:0] size, input logic [1:0] a);
        logic [3:0] lanes;
        case (size)
            HSIZE_BYTE: lanes = 4'b0001 << a;
            HSIZE_HALF: lanes = a[1] ? 4'b1100 : 4'b0011;
            HSIZE_WORD: lanes = 4'b1111;
            default:    lanes = 4'b0000;
        endcase
        return lanes;
    endfunction

    // True when the size is supported and the address is naturally aligned for it.
    function automatic logic size_aligned(input logic [2:0] size, input logic [1:0] a);
        logic ok;
        case (size)
            HSIZE_BYTE: ok = 1'b1;
            HSIZE_HALF: ok = (a[0] == 1'b0);
            HSIZE_WORD: ok = (a == 2'b00);
            default:    ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/ahb_ram_responder_if.sv
// rtl/ahb_ram_responder_if.sv - AHB-Lite responder-side bus bundle with master/slave modports
// Signals keep the responder's port names; _i are driven by the master, _o by the responder.
interface ahb_ram_responder_if;

    logic        s_hsel_i;
    logic [31:0] s_haddr_i;
    logic [31:0] s_hwdata_i;
    logic [2:0]  s_hburst_i;
    logic        s_hmastlock_i;
    logic [3:0]  s_hprot_i;
    logic [2:0]  s_hsize_i;
    logic [1:0]  s_htrans_i;
    logic        s_hwrite_i;
    logic        s_hready_i;
    logic [31:0] s_hrdata_o;
    logic        s_hreadyout_o;
    logic        s_hresp_o;

    modport master (
        output s_hsel_i, s_haddr_i, s_hwdata_i, s_hburst_i, s_hmastlock_i, s_hprot_i,
               s_hsize_i, s_htrans_i, s_hwrite_i, s_hready_i,
        input  s_hrdata_o, s_hreadyout_o, s_hresp_o
    );

    modport slave (
        input  s_hsel_i, s_haddr_i, s_hwdata_i, s_hburst_i, s_hmastlock_i, s_hprot_i,
               s_hsize_i, s_htrans_i, s_hwrite_i, s_hready_i,
        output s_hrdata_o, s_hreadyout_o, s_hresp_o
    );

endinterface

// File: rtl/ahb_ram_array.sv
// rtl/ahb_ram_array.sv - single-port word RAM, byte write enables, sync write, async read
// Ports: clk; we[3:0] per-byte write enable; addr word index; wdata write word; rdata read word.
module ahb_ram_array #(
    parameter int WORDS = 16384,
    parameter int AW    = $clog2(WORDS)
) (
    input  logic          clk,
    input  logic [3:0]    we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [WORDS];

    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (we[b]) begin
                mem[addr][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/ahb_ram_responder.sv
// rtl/ahb_ram_responder.sv - AHB-Lite RAM responder with configurable wait states and ERROR response
// Ports: s_clk_i clock; s_rst_i sync active-high reset; bus AHB-Lite slave modport
//        (hsel/haddr/hwdata/hburst/hmastlock/hprot/hsize/htrans/hwrite/hready in,
//         hrdata/hreadyout/hresp out).
module ahb_ram_responder
    import ahb_ram_responder_pkg::*;
#(
    parameter int          MEM_WORDS   = 16384,
    parameter logic [31:0] BASE_ADD    = 32'h0000_0000,
    parameter int          WAIT_STATES = 0
) (
    input  logic                   s_clk_i,
    input  logic                   s_rst_i,
    ahb_ram_responder_if.slave     bus
);

    localparam int         AW = $clog2(MEM_WORDS);
    localparam logic [3:0] WS = 4'(WAIT_STATES);

    ahbr_state_e   state;
    logic [3:0]    wait_cnt;
    logic          dp_valid;   // legal transfer owns the current data phase
    logic          dp_write;
    logic [AW-1:0] dp_idx;
    logic [3:0]    dp_lanes;
    logic          readyout_q;
    logic          hresp_q;

    logic          accept;
    logic          in_range;
    logic          legal;
    logic          completing;
    logic [31:0]   rd_word;

    assign accept = bus.s_hsel_i & bus.s_hready_i &
                    ((bus.s_htrans_i == HTRANS_NONSEQ) || (bus.s_htrans_i == HTRANS_SEQ));

    // BASE_ADD is aligned to the window size, so the window check reduces to the upper bits.
    assign in_range = (bus.s_haddr_i[31:AW+2] == BASE_ADD[31:AW+2]);
    assign legal    = in_range & size_aligned(bus.s_hsize_i, bus.s_haddr_i[1:0]);

    // Back in IDLE with a live transfer means this is its completing (readyout = 1) cycle.
    assign completing = dp_valid & (state == AHBR_IDLE);

    always_ff @(posedge s_clk_i) begin
        if (s_rst_i) begin
            state      <= AHBR_IDLE;
            wait_cnt   <= 4'd0;
            dp_valid   <= 1'b0;
            dp_write   <= 1'b0;
            dp_idx     <= '0;
            dp_lanes   <= 4'd0;
            readyout_q <= 1'b1;
            hresp_q    <= HRESP_OKAY;
        end else begin
            case (state)
                AHBR_IDLE, AHBR_ERR2: begin
                    if (accept) begin
                        dp_write <= bus.s_hwrite_i;
                        dp_idx   <= bus.s_haddr_i[AW+1:2];
                        dp_lanes <= byte_lanes(bus.s_hsize_i, bus.s_haddr_i[1:0]);
                        if (!legal) begin
                            state      <= AHBR_ERR1;
                            dp_valid   <= 1'b0;
                            readyout_q <= 1'b0;
                            hresp_q    <= HRESP_ERROR;
                        end else if (WS == 4'd0) begin
                            state      <= AHBR_IDLE;
                            dp_valid   <= 1'b1;
                            readyout_q <= 1'b1;
                            hresp_q    <= HRESP_OKAY;
                        end else begin
                            state      <= AHBR_WAIT;
                            wait_cnt   <= WS;
                            dp_valid   <= 1'b1;
                            readyout_q <= 1'b0;
                            hresp_q    <= HRESP_OKAY;
                        end
                    end else begin
                        state      <= AHBR_IDLE;
                        dp_valid   <= 1'b0;
                        readyout_q <= 1'b1;
                        hresp_q    <= HRESP_OKAY;
                    end
                end
                AHBR_WAIT: begin
                    wait_cnt <= wait_cnt - 4'd1;
                    if (wait_cnt == 4'd1) begin
                        state      <= AHBR_IDLE;
                        readyout_q <= 1'b1;
                    end
                end
                AHBR_ERR1: begin
                    state      <= AHBR_ERR2;
                    readyout_q <= 1'b1;
                    hresp_q    <= HRESP_ERROR;
                end
                default: begin
                    state      <= AHBR_IDLE;
                    dp_valid   <= 1'b0;
                    readyout_q <= 1'b1;
                    hresp_q    <= HRESP_OKAY;
                end
            endcase
        end
    end

    // Writes land at the edge that ends the completing cycle; reset blocks a pending commit.
    ahb_ram_array #(
        .WORDS (MEM_WORDS),
        .AW    (AW)
    ) u_array (
        .clk   (s_clk_i),
        .we    (dp_lanes & {4{completing & dp_write & ~s_rst_i}}),
        .addr  (dp_idx),
        .wdata (bus.s_hwdata_i),
        .rdata (rd_word)
    );

    assign bus.s_hrdata_o    = (completing & ~dp_write) ? rd_word : 32'd0;
    assign bus.s_hreadyout_o = readyout_q;
    assign bus.s_hresp_o     = hresp_q;

    // Burst, lock and protection carry no meaning for a plain RAM.
    logic unused_ok;
    assign unused_ok = &{1'b0, bus.s_hburst_i, bus.s_hmastlock_i, bus.s_hprot_i};

endmodule

// File: tb/tb_ahb_ram_responder.sv
// tb/tb_ahb_ram_responder.sv - directed self-checking bench for ahb_ram_responder
module tb_ahb_ram_responder;
    import ahb_ram_responder_pkg::*;

    localparam logic [31:0] BASE = 32'h0000_1000;
    localparam int          WORDS = 256;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;
    int   lows;
    int   nz;

    always #5 clk = ~clk;

    ahb_ram_responder_if b0 ();
    ahb_ram_responder_if b3 ();

    assign b0.s_hready_i = b0.s_hreadyout_o;
    assign b3.s_hready_i = b3.s_hreadyout_o;

    ahb_ram_responder #(.MEM_WORDS(WORDS), .BASE_ADD(BASE), .WAIT_STATES(0)) dut0 (
        .s_clk_i (clk),
        .s_rst_i (rst),
        .bus     (b0)
    );

    ahb_ram_responder #(.MEM_WORDS(WORDS), .BASE_ADD(BASE), .WAIT_STATES(3)) dut3 (
        .s_clk_i (clk),
        .s_rst_i (rst),
        .bus     (b3)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic addr(input bit u3, input logic sel, input logic [1:0] trans,
                        input logic wr, input logic [2:0] size, input logic [31:0] a);
        if (u3) begin
            b3.s_hsel_i = sel; b3.s_htrans_i = trans; b3.s_hwrite_i = wr;
            b3.s_hsize_i = size; b3.s_haddr_i = a;
        end else begin
            b0.s_hsel_i = sel; b0.s_htrans_i = trans; b0.s_hwrite_i = wr;
            b0.s_hsize_i = size; b0.s_haddr_i = a;
        end
    endtask

    task automatic idle(input bit u3);
        addr(u3, 1'b0, HTRANS_IDLE, 1'b0, HSIZE_WORD, 32'd0);
    endtask

    // Counts readyout-low cycles on the wait-state instance, bounded at 20.
    task automatic wait_lows(output int n, output int nzero);
        n = 0;
        nzero = 0;
        while (b3.s_hreadyout_o === 1'b0 && n < 20) begin
            if (b3.s_hrdata_o !== 32'd0) nzero++;
            n++;
            step();
        end
    endtask

    initial begin
        b0.s_hwdata_i = 32'd0; b0.s_hburst_i = 3'd0; b0.s_hmastlock_i = 1'b0; b0.s_hprot_i = 4'd0;
        b3.s_hwdata_i = 32'd0; b3.s_hburst_i = 3'd0; b3.s_hmastlock_i = 1'b0; b3.s_hprot_i = 4'd0;
        idle(0);
        idle(1);

        step();
        step();
        chk("rst_ready0", {31'd0, b0.s_hreadyout_o}, 32'd1);
        chk("rst_resp0",  {31'd0, b0.s_hresp_o}, 32'd0);
        chk("rst_rdata0", b0.s_hrdata_o, 32'd0);
        chk("rst_ready3", {31'd0, b3.s_hreadyout_o}, 32'd1);
        rst = 1'b0;
        step();

        // word write then back-to-back read of the same word
        addr(0, 1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_WORD, BASE + 32'h10);
        step();
        b0.s_hwdata_i = 32'hDEADBEEF;
        addr(0, 1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, BASE + 32'h10);
        chk("wr_ready", {31'd0, b0.s_hreadyout_o}, 32'd1);
        step();
        idle(0);
        b0.s_hwdata_i = 32'd0;
        chk("raw_data",  b0.s_hrdata_o, 32'hDEADBEEF);
        chk("raw_resp",  {31'd0, b0.s_hresp_o}, 32'd0);
        chk("raw_ready", {31'd0, b0.s_hreadyout_o}, 32'd1);
        step();
        chk("idle_rdata", b0.s_hrdata_o, 32'd0);

        // byte write to lane 3, other lanes carry junk that must be ignored
        addr(0, 1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_BYTE, BASE + 32'h13);
        step();
        b0.s_hwdata_i = 32'hA511_2233;
        addr(0, 1'b1, HTRANS_SEQ, 1'b0, HSIZE_WORD, BASE + 32'h10);
        step();
        idle(0);
        chk("byte_wr", b0.s_hrdata_o, 32'hA5ADBEEF);
        step();

        // half write to upper half
        addr(0, 1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_HALF, BASE + 32'h12);
        step();
        b0.s_hwdata_i = 32'h7788_9900;
        addr(0, 1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, BASE + 32'h10);
        step();
        idle(0);
        chk("half_wr", b0.s_hrdata_o, 32'h7788BEEF);
        step();

        // misaligned word read
        addr(0, 1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, BASE + 32'h2);
        step();
        idle(0);
        chk("mis_err1_ready", {31'd0, b0.s_hreadyout_o}, 32'd0);
        chk("mis_err1_resp",  {31'd0, b0.s_hresp_o}, 32'd1);
        step();
        chk("mis_err2_ready", {31'd0, b0.s_hreadyout_o}, 32'd1);
        chk("mis_err2_resp",  {31'd0, b0.s_hresp_o}, 32'd1);
        chk("mis_err2_rdata", b0.s_hrdata_o, 32'd0);
        step();
        chk("mis_after_resp", {31'd0, b0.s_hresp_o}, 32'd0);

        // read one word past the end of the window
        addr(0, 1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, BASE + WORDS * 4);
        step();
        idle(0);
        chk("oor_err1_ready", {31'd0, b0.s_hreadyout_o}, 32'd0);
        chk("oor_err1_resp",  {31'd0, b0.s_hresp_o}, 32'd1);
        step();
        chk("oor_err2_ready", {31'd0, b0.s_hreadyout_o}, 32'd1);
        chk("oor_err2_resp",  {31'd0, b0.s_hresp_o}, 32'd1);
        step();

        // oversize transfer
        addr(0, 1'b1, HTRANS_NONSEQ, 1'b0, 3'b011, BASE + 32'h10);
        step();
        idle(0);
        chk("size_err1_resp", {31'd0, b0.s_hresp_o}, 32'd1);
        step();
        step();

        // misaligned word write must not touch the word
        addr(0, 1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_WORD, BASE + 32'h11);
        step();
        b0.s_hwdata_i = 32'hFFFF_FFFF;
        idle(0);
        chk("miswr_resp", {31'd0, b0.s_hresp_o}, 32'd1);
        step();
        step();
        b0.s_hwdata_i = 32'd0;
        addr(0, 1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, BASE + 32'h10);
        step();
        idle(0);
        chk("miswr_kept", b0.s_hrdata_o, 32'h7788BEEF);
        step();

        // BUSY, IDLE and unselected writes are no-ops
        addr(0, 1'b1, HTRANS_BUSY, 1'b1, HSIZE_WORD, BASE + 32'h10);
        step();
        b0.s_hwdata_i = 32'h1111_1111;
        addr(0, 1'b1, HTRANS_IDLE, 1'b1, HSIZE_WORD, BASE + 32'h10);
        chk("busy_ready", {31'd0, b0.s_hreadyout_o}, 32'd1);
        chk("busy_resp",  {31'd0, b0.s_hresp_o}, 32'd0);
        step();
        addr(0, 1'b0, HTRANS_NONSEQ, 1'b1, HSIZE_WORD, BASE + 32'h10);
        chk("idle_ready", {31'd0, b0.s_hreadyout_o}, 32'd1);
        chk("idle_resp",  {31'd0, b0.s_hresp_o}, 32'd0);
        step();
        idle(0);
        chk("nosel_ready", {31'd0, b0.s_hreadyout_o}, 32'd1);
        chk("nosel_resp",  {31'd0, b0.s_hresp_o}, 32'd0);
        step();
        b0.s_hwdata_i = 32'd0;
        addr(0, 1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, BASE + 32'h10);
        step();
        idle(0);
        chk("noop_kept", b0.s_hrdata_o, 32'h7788BEEF);
        step();

        // three wait states: write, then read with a pipelined next read held on the bus
        addr(1, 1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_WORD, BASE + 32'h20);
        step();
        b3.s_hwdata_i = 32'h1234_5678;
        idle(1);
        wait_lows(lows, nz);
        chk("ws_wr_lows",  lows, 32'd3);
        chk("ws_wr_ready", {31'd0, b3.s_hreadyout_o}, 32'd1);
        step();

        addr(1, 1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, BASE + 32'h20);
        step();
        addr(1, 1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, BASE + 32'h20);
        wait_lows(lows, nz);
        chk("ws_rd_lows",  lows, 32'd3);
        chk("ws_rd_zero",  nz, 32'd0);
        chk("ws_rd_data",  b3.s_hrdata_o, 32'h1234_5678);
        chk("ws_rd_resp",  {31'd0, b3.s_hresp_o}, 32'd0);
        step();
        idle(1);
        wait_lows(lows, nz);
        chk("ws_pipe_lows", lows, 32'd3);
        chk("ws_pipe_data", b3.s_hrdata_o, 32'h1234_5678);
        step();

        // reset during the wait of a pending write aborts it
        addr(1, 1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_WORD, BASE + 32'h20);
        step();
        b3.s_hwdata_i = 32'hCAFE_F00D;
        idle(1);
        chk("rw_wait_ready", {31'd0, b3.s_hreadyout_o}, 32'd0);
        step();
        rst = 1'b1;
        step();
        chk("rw_rst_ready", {31'd0, b3.s_hreadyout_o}, 32'd1);
        chk("rw_rst_resp",  {31'd0, b3.s_hresp_o}, 32'd0);
        rst = 1'b0;
        b3.s_hwdata_i = 32'd0;
        addr(1, 1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, BASE + 32'h20);
        step();
        idle(1);
        wait_lows(lows, nz);
        chk("rw_rst_lows", lows, 32'd3);
        chk("rw_old_data", b3.s_hrdata_o, 32'h1234_5678);
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
